// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serializer.
// Accepts the same byte-plus-strobe pair that uart_rx produces, so it can echo directly.
module uart_tx_fifo #(
  parameter int BAUD_CNT = 56,
  parameter int FIFO_AW  = 2
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic [7:0] tx_data,
  input  logic       pi_flag,
  output logic       rs232_tx,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam logic [BW-1:0]    BAUD_LAST = BW'(BAUD_CNT - 1);
  localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wrPtr;
  logic [FIFO_AW-1:0] r_rdPtr;
  logic [FIFO_AW:0]   r_count;
  state_t             r_state;
  logic [BW-1:0]      r_baud;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic               r_tx;
  logic               r_busy;
  logic               r_full;
  logic               r_ovf;

  state_t             w_stateNext;
  logic [BW-1:0]      w_baudNext;
  logic [2:0]         w_bitNext;
  logic [7:0]         w_shiftNext;
  logic               w_txNext;
  logic               w_pop;
  logic               w_push;
  logic               w_empty;
  logic               w_isFull;
  logic               w_baudDone;
  logic [FIFO_AW:0]   w_countNext;

  assign w_empty    = (r_count == '0);
  assign w_isFull   = (r_count == DEPTH_C);
  assign w_baudDone = (r_baud == BAUD_LAST);
  // A full FIFO still accepts a byte when the serializer pops in the same cycle.
  assign w_push     = pi_flag && (!w_isFull || w_pop);

  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + 1'b1;
      2'b01:   w_countNext = r_count - 1'b1;
      default: w_countNext = r_count;
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    w_baudNext  = r_baud;
    w_bitNext   = r_bit;
    w_shiftNext = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shiftNext = r_mem[r_rdPtr];
          w_stateNext = START;
          w_baudNext  = '0;
        end
      end
      START: begin
        if (w_baudDone) begin
          w_stateNext = DATA;
          w_baudNext  = '0;
          w_bitNext   = '0;
        end else begin
          w_baudNext = r_baud + 1'b1;
        end
      end
      DATA: begin
        if (w_baudDone) begin
          w_baudNext  = '0;
          w_shiftNext = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_stateNext = STOP;
          end else begin
            w_bitNext = r_bit + 1'b1;
          end
        end else begin
          w_baudNext = r_baud + 1'b1;
        end
      end
      STOP: begin
        if (w_baudDone) begin
          w_baudNext = '0;
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shiftNext = r_mem[r_rdPtr];
            w_stateNext = START;
          end else begin
            w_stateNext = IDLE;
          end
        end else begin
          w_baudNext = r_baud + 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_txNext = 1'b1;
    case (w_stateNext)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = w_shiftNext[0];
      default: w_txNext = 1'b1;
    endcase
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge sclk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= tx_data;
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      r_count <= w_countNext;
      r_state <= w_stateNext;
      r_baud  <= w_baudNext;
      r_bit   <= w_bitNext;
      r_shift <= w_shiftNext;
      r_tx    <= w_txNext;
      r_busy  <= (w_stateNext != IDLE) || (w_countNext != '0);
      r_full  <= (w_countNext == DEPTH_C);
      r_ovf   <= pi_flag && w_isFull && !w_pop;
    end
  end

  assign rs232_tx  = r_tx;
  assign tx_busy   = r_busy;
  assign fifo_full = r_full;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a line monitor decodes every frame
// cycle by cycle against bytes queued in a scoreboard when they are strobed in.
module tb_uart_tx_fifo;

  localparam int BAUD  = 56;
  localparam int FRAME = 10 * BAUD;

  logic       sclk    = 1'b0;
  logic       s_rst_n = 1'b1;
  logic       pi_flag = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rs232_tx;
  logic       tx_busy;
  logic       fifo_full;
  logic       overflow;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [7:0] expQ[$];
  int         startQ[$];
  int         rxCount    = 0;
  int         abortCount = 0;

  int   ovCount       = 0;
  int   ovLast        = -1;
  int   fullSeen      = 0;
  int   fullRiseCycle = -1;
  int   busyFallCycle = -1;
  logic prevFull      = 1'b0;
  logic prevBusy      = 1'b0;

  logic [9:0] monFrame;
  logic [7:0] monExp;
  logic [7:0] monRx;
  logic       monHaveExp;
  logic       monAbort;
  int         monBad;

  uart_tx_fifo #(
    .BAUD_CNT(BAUD),
    .FIFO_AW (2)
  ) dut (
    .sclk     (sclk),
    .s_rst_n  (s_rst_n),
    .tx_data  (tx_data),
    .pi_flag  (pi_flag),
    .rs232_tx (rs232_tx),
    .tx_busy  (tx_busy),
    .fifo_full(fifo_full),
    .overflow (overflow)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  // Event tracker for overflow pulses, fifo_full rises and tx_busy falls.
  initial begin
    forever begin
      @(negedge sclk);
      if (overflow === 1'b1) begin
        ovCount++;
        ovLast = cyc;
      end
      if (fifo_full === 1'b1) begin
        fullSeen++;
        if (prevFull !== 1'b1) fullRiseCycle = cyc;
      end
      if (prevBusy === 1'b1 && tx_busy === 1'b0) busyFallCycle = cyc;
      prevFull = fifo_full;
      prevBusy = tx_busy;
    end
  end

  // Line monitor: each frame must match the head of the scoreboard on every cycle.
  initial begin
    forever begin
      @(negedge sclk);
      if (s_rst_n === 1'b1 && rs232_tx === 1'b0) begin
        startQ.push_back(cyc);
        monHaveExp = 1'b0;
        monExp     = 8'h00;
        if (expQ.size() > 0) begin
          monHaveExp = 1'b1;
          monExp     = expQ.pop_front();
        end
        monFrame = {1'b1, monExp, 1'b0};
        monBad   = 0;
        monAbort = 1'b0;
        monRx    = 8'h00;
        for (int c = 0; c < FRAME; c++) begin
          if (c > 0) @(negedge sclk);
          if (s_rst_n !== 1'b1) begin
            monAbort = 1'b1;
            break;
          end
          if (rs232_tx !== monFrame[c / BAUD]) monBad++;
          if ((c % BAUD) == (BAUD / 2) && (c / BAUD) >= 1 && (c / BAUD) <= 8)
            monRx[(c / BAUD) - 1] = rs232_tx;
        end
        if (monAbort) begin
          abortCount++;
        end else begin
          rxCount++;
          compared++;
          if (!monHaveExp || monBad != 0) begin
            mismatched++;
            $display("[TB] FAIL frame: got byte 0x%02h with %0d bad bit-cycles, expected byte 0x%02h (queued=%0d) with 0 bad",
                     monRx, monBad, monExp, monHaveExp);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitIdle(input int budget, output bit timedOut);
    int n;
    n = 0;
    timedOut = 1'b0;
    repeat (3) @(negedge sclk);
    while (tx_busy !== 1'b0 || rs232_tx !== 1'b1) begin
      @(negedge sclk);
      n++;
      if (n > budget) begin
        timedOut = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge sclk);
  endtask

  task automatic pulseByte(input logic [7:0] b);
    @(posedge sclk); #1;
    tx_data = b;
    pi_flag = 1'b1;
    expQ.push_back(b);
    @(posedge sclk); #1;
    pi_flag = 1'b0;
    tx_data = 8'($urandom);
  endtask

  task automatic test_reset();
    s_rst_n = 1'b1;
    #2 s_rst_n = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    compared++;
    if (rs232_tx !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_tx: got %b, expected 1", rs232_tx);
    end
    compared++;
    if (tx_busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_busy: got %b, expected 0", tx_busy);
    end
    compared++;
    if (fifo_full !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_full: got %b, expected 0", fifo_full);
    end
    compared++;
    if (overflow !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_overflow: got %b, expected 0", overflow);
    end
    s_rst_n = 1'b1;
    repeat (4) @(negedge sclk);
    compared++;
    if (rs232_tx !== 1'b1 || tx_busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL post_reset_idle: got tx=%b busy=%b, expected tx=1 busy=0", rs232_tx, tx_busy);
    end
  endtask

  task automatic test_single_byte();
    int  sBase, fBase, rBase, n0, got;
    bit  to;
    sBase = startQ.size();
    fBase = fullSeen;
    rBase = rxCount;
    @(posedge sclk); #1;
    n0      = cyc;
    tx_data = 8'h55;
    pi_flag = 1'b1;
    expQ.push_back(8'h55);
    @(posedge sclk); #1;
    pi_flag = 1'b0;
    tx_data = 8'hAA;
    waitIdle(2000, to);
    compared++;
    if (to) begin
      mismatched++;
      $display("[TB] FAIL single_timeout: got busy=%b after budget, expected idle", tx_busy);
    end
    got = (startQ.size() > sBase) ? startQ[sBase] : -1;
    compared++;
    if (got != n0 + 2) begin
      mismatched++;
      $display("[TB] FAIL single_latency: got start cycle %0d, expected %0d", got, n0 + 2);
    end
    compared++;
    if (busyFallCycle != got + FRAME) begin
      mismatched++;
      $display("[TB] FAIL single_busy_fall: got cycle %0d, expected %0d", busyFallCycle, got + FRAME);
    end
    compared++;
    if (fullSeen != fBase) begin
      mismatched++;
      $display("[TB] FAIL single_full: got %0d full cycles, expected 0", fullSeen - fBase);
    end
    compared++;
    if (rxCount != rBase + 1) begin
      mismatched++;
      $display("[TB] FAIL single_count: got %0d frames, expected 1", rxCount - rBase);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytesIn [4];
    int  sBase, oBase, rBase, n0, first;
    bit  to;
    bytesIn[0] = 8'h12; bytesIn[1] = 8'h34; bytesIn[2] = 8'h56; bytesIn[3] = 8'h78;
    sBase = startQ.size();
    oBase = ovCount;
    rBase = rxCount;
    @(posedge sclk); #1;
    n0 = cyc;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge sclk); #1;
      end
      tx_data = bytesIn[i];
      pi_flag = 1'b1;
      expQ.push_back(bytesIn[i]);
    end
    @(posedge sclk); #1;
    pi_flag = 1'b0;
    waitIdle(4000, to);
    compared++;
    if (to || startQ.size() != sBase + 4) begin
      mismatched++;
      $display("[TB] FAIL b2b_frames: got %0d starts (timeout=%0d), expected 4", startQ.size() - sBase, to);
    end else begin
      first = startQ[sBase];
      compared++;
      if (first != n0 + 2) begin
        mismatched++;
        $display("[TB] FAIL b2b_latency: got start %0d, expected %0d", first, n0 + 2);
      end
      for (int i = 1; i < 4; i++) begin
        compared++;
        if (startQ[sBase + i] - startQ[sBase + i - 1] != FRAME) begin
          mismatched++;
          $display("[TB] FAIL b2b_gap%0d: got %0d cycles, expected %0d", i,
                   startQ[sBase + i] - startQ[sBase + i - 1], FRAME);
        end
      end
      compared++;
      if (busyFallCycle - first != 4 * FRAME) begin
        mismatched++;
        $display("[TB] FAIL b2b_total: got %0d cycles, expected %0d", busyFallCycle - first, 4 * FRAME);
      end
    end
    compared++;
    if (ovCount != oBase || rxCount != rBase + 4) begin
      mismatched++;
      $display("[TB] FAIL b2b_counts: got overflow=%0d frames=%0d, expected 0 and 4", ovCount - oBase, rxCount - rBase);
    end
  endtask

  task automatic test_overflow();
    int  oBase, rBase, n0;
    bit  to;
    oBase = ovCount;
    rBase = rxCount;
    @(posedge sclk); #1;
    n0 = cyc;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge sclk); #1;
      end
      tx_data = 8'hA0 + 8'(i);
      pi_flag = 1'b1;
      if (i < 5) expQ.push_back(8'hA0 + 8'(i));
    end
    @(posedge sclk); #1;
    pi_flag = 1'b0;
    tx_data = 8'hFF;
    waitIdle(4000, to);
    compared++;
    if (fullRiseCycle != n0 + 5) begin
      mismatched++;
      $display("[TB] FAIL ovf_full_rise: got cycle %0d, expected %0d", fullRiseCycle, n0 + 5);
    end
    compared++;
    if (ovCount - oBase != 1 || ovLast != n0 + 6) begin
      mismatched++;
      $display("[TB] FAIL ovf_pulse: got %0d pulses last at %0d, expected 1 at %0d", ovCount - oBase, ovLast, n0 + 6);
    end
    compared++;
    if (to || rxCount != rBase + 5) begin
      mismatched++;
      $display("[TB] FAIL ovf_frames: got %0d frames (timeout=%0d), expected 5", rxCount - rBase, to);
    end
  endtask

  task automatic test_full_pop_write();
    int  sBase, oBase, rBase, n, s0;
    bit  to;
    sBase = startQ.size();
    oBase = ovCount;
    rBase = rxCount;
    for (int i = 0; i < 5; i++) begin
      @(posedge sclk); #1;
      tx_data = 8'h5A + 8'(i * 17);
      pi_flag = 1'b1;
      expQ.push_back(8'h5A + 8'(i * 17));
    end
    @(posedge sclk); #1;
    pi_flag = 1'b0;
    n = 0;
    while (startQ.size() <= sBase && n < 200) begin
      @(negedge sclk);
      n++;
    end
    compared++;
    if (startQ.size() <= sBase) begin
      mismatched++;
      $display("[TB] FAIL fullpop_start: got no frame in %0d cycles, expected one", n);
    end else begin
      s0 = startQ[sBase];
      while (cyc < s0 + FRAME - 1) begin
        @(posedge sclk); #1;
      end
      compared++;
      if (fifo_full !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL fullpop_pre_full: got %b, expected 1", fifo_full);
      end
      tx_data = 8'hE7;
      pi_flag = 1'b1;
      expQ.push_back(8'hE7);
      @(posedge sclk); #1;
      pi_flag = 1'b0;
      tx_data = 8'h00;
      compared++;
      if (fifo_full !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL fullpop_post_full: got %b, expected 1", fifo_full);
      end
    end
    waitIdle(5000, to);
    compared++;
    if (ovCount != oBase) begin
      mismatched++;
      $display("[TB] FAIL fullpop_overflow: got %0d pulses, expected 0", ovCount - oBase);
    end
    compared++;
    if (to || rxCount != rBase + 6) begin
      mismatched++;
      $display("[TB] FAIL fullpop_frames: got %0d frames (timeout=%0d), expected 6", rxCount - rBase, to);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] pats [4];
    int  oBase, rBase;
    bit  to;
    pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h3C; pats[3] = 8'hC3;
    oBase = ovCount;
    rBase = rxCount;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge sclk);
      pulseByte(pats[i]);
    end
    waitIdle(4000, to);
    compared++;
    if (to || rxCount != rBase + 4 || ovCount != oBase) begin
      mismatched++;
      $display("[TB] FAIL patterns: got %0d frames %0d overflows (timeout=%0d), expected 4 and 0",
               rxCount - rBase, ovCount - oBase, to);
    end
  endtask

  task automatic test_reset_midframe();
    int  sBase, aBase, rBase, n, s0, bad;
    bit  to;
    sBase = startQ.size();
    aBase = abortCount;
    for (int i = 0; i < 3; i++) begin
      @(posedge sclk); #1;
      tx_data = (i == 0) ? 8'h0F : 8'h11 * 8'(i);
      pi_flag = 1'b1;
      if (i == 0) expQ.push_back(8'h0F);
    end
    @(posedge sclk); #1;
    pi_flag = 1'b0;
    n = 0;
    while (startQ.size() <= sBase && n < 200) begin
      @(negedge sclk);
      n++;
    end
    s0 = (startQ.size() > sBase) ? startQ[sBase] : cyc;
    while (cyc < s0 + 4 * BAUD + 20) begin
      @(posedge sclk); #1;
    end
    s_rst_n = 1'b0;
    #1;
    compared++;
    if (rs232_tx !== 1'b1 || tx_busy !== 1'b0 || fifo_full !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset_async: got tx=%b busy=%b full=%b, expected 1 0 0", rs232_tx, tx_busy, fifo_full);
    end
    repeat (3) @(posedge sclk);
    #1;
    s_rst_n = 1'b1;
    expQ.delete();
    rBase = rxCount;
    bad = 0;
    repeat (3 * FRAME) begin
      @(negedge sclk);
      if (rs232_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    compared++;
    if (bad != 0 || rxCount != rBase) begin
      mismatched++;
      $display("[TB] FAIL midreset_idle: got %0d non-idle cycles %0d frames, expected 0 and 0", bad, rxCount - rBase);
    end
    compared++;
    if (abortCount != aBase + 1) begin
      mismatched++;
      $display("[TB] FAIL midreset_abort: got %0d aborted frames, expected 1", abortCount - aBase);
    end
    pulseByte(8'h81);
    waitIdle(2000, to);
    compared++;
    if (to || rxCount != rBase + 1) begin
      mismatched++;
      $display("[TB] FAIL midreset_resume: got %0d frames (timeout=%0d), expected 1", rxCount - rBase, to);
    end
  endtask

  initial begin
    $display("[TB] uart_tx_fifo bench starting");
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_full_pop_write();
    test_patterns();
    test_reset_midframe();
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d bytes left, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
